cam_capture: RTL and testbench

Parametrised OV7670 pixel capture block, successor to the fixed 160×120 RGB332 capture stage. Sits between the camera's parallel bus (pclk domain) and the frame-buffer RAM write port. Pairs the two RGB565 bytes per pixel and converts them to a selectable output format (RGB332, RGB444 or 8-bit grey). Adds power-of-two decimation, a frame-arm input, frame-done signalling and bounds protection on the frame-buffer address.

---
 rtl/cam_capture.sv | 171 +++++++++++++++++
 tb/tb_cam_capture.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// cam_capture: pairs OV7670 RGB565 bytes into pixels, converts them to RGB332/RGB444/GRAY8,
// decimates and writes them to a bounded frame buffer. Define CAM_CAPTURE_STATS_EN for frame_cnt/ovf.
module cam_capture #(
    parameter int AW      = 15,
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int DEC     = 1,
    parameter int FMT     = 0,
    parameter int DW      = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          busy
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [7:0]    frame_cnt,
    output logic          ovf
`endif
);

    localparam int H_OUT = H_PIX / DEC;
    localparam int V_OUT = V_LINES / DEC;
    localparam int NPIX  = H_OUT * V_OUT;

    localparam logic [15:0] H_LIM    = 16'(H_PIX);
    localparam logic [15:0] V_LIM    = 16'(V_LINES);
    localparam logic [15:0] DEC_MASK = 16'(DEC - 1);
    localparam logic [AW:0] NPIX_LIM = (AW + 1)'(NPIX);
    localparam logic [AW:0] WR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t       state;
    logic         vsync_q;
    logic         phase;
    logic         line_seen;
    logic [7:0]   hi_byte;
    logic [15:0]  col;
    logic [15:0]  row;
    logic [AW:0]  wr_cnt;
    logic         pend;
    logic [15:0]  pend_pix;

    logic vs_rise, vs_fall;
    logic in_bounds, on_grid, room, keep_px;

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign in_bounds = (col < H_LIM) && (row < V_LIM);
    assign on_grid   = ((col & DEC_MASK) == 16'd0) && ((row & DEC_MASK) == 16'd0);
    assign room      = wr_cnt < NPIX_LIM;
    assign keep_px   = in_bounds && on_grid && room;

    // Pixel conversion works on the pixel held in the one-stage write pipeline.
    logic [4:0]    r5, b5;
    logic [5:0]    g6;
    logic [7:0]    r8, g8, b8;
    logic [10:0]   y_sum;
    logic [DW-1:0] conv;

    always_comb begin
        r5    = pend_pix[15:11];
        g6    = pend_pix[10:5];
        b5    = pend_pix[4:0];
        r8    = {r5, r5[4:2]};
        g8    = {g6, g6[5:4]};
        b8    = {b5, b5[4:2]};
        y_sum = {2'b00, r8, 1'b0} + {1'b0, g8, 2'b00} + {3'b000, g8} + {3'b000, b8};
        case (FMT)
            0:       conv = DW'({r5[4:2], g6[5:3], b5[4:3]});
            1:       conv = DW'({r5[4:1], g6[5:2], b5[4:1]});
            default: conv = DW'(y_sum >> 3);
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vsync_q     <= 1'b0;
            phase       <= 1'b0;
            line_seen   <= 1'b0;
            hi_byte     <= 8'd0;
            col         <= 16'd0;
            row         <= 16'd0;
            wr_cnt      <= '0;
            pend        <= 1'b0;
            pend_pix    <= 16'd0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
            frame_cnt   <= 8'd0;
            ovf         <= 1'b0;
`endif
        end else begin
            vsync_q    <= vsync;
            frame_done <= 1'b0;
            pend       <= 1'b0;
            px_wr      <= pend;
            if (pend) begin
                mem_px_addr <= wr_cnt[AW-1:0];
                mem_px_data <= conv;
                wr_cnt      <= wr_cnt + WR_ONE;
            end

            case (state)
                IDLE: begin
                    if (cap_en) begin
                        state <= WAIT_VS;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state       <= ACTIVE;
                        col         <= 16'd0;
                        row         <= 16'd0;
                        wr_cnt      <= '0;
                        phase       <= 1'b0;
                        line_seen   <= 1'b0;
                        mem_px_addr <= '0;
                    end
                end
                ACTIVE: begin
                    // A low byte is still paired even when vsync rises on the same edge.
                    if (href && phase) begin
                        pend     <= keep_px;
                        pend_pix <= {hi_byte, px_data};
                        if (col < H_LIM) col <= col + 16'd1;
`ifdef CAM_CAPTURE_STATS_EN
                        if (!in_bounds || (on_grid && !room)) ovf <= 1'b1;
`endif
                    end
                    if (vs_rise) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        phase      <= 1'b0;
                        line_seen  <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
                        frame_cnt  <= frame_cnt + 8'd1;
`endif
                    end else if (href) begin
                        phase     <= ~phase;
                        line_seen <= 1'b1;
                        if (!phase) hi_byte <= px_data;
                    end else begin
                        phase <= 1'b0;
                        if (line_seen) begin
                            line_seen <= 1'b0;
                            col       <= 16'd0;
                            if (row < V_LIM) row <= row + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: drives randomized OV7670 frames into three cam_capture configurations
// (RGB332, RGB444 with 2x decimation, GRAY8) and checks every write against a frame-level model.
module tb_cam_capture;

    localparam int TB_H  = 16;
    localparam int TB_V  = 12;
    localparam int AW    = 8;
    localparam int NPIX0 = TB_H * TB_V;
    localparam int NPIX1 = (TB_H / 2) * (TB_V / 2);
    localparam int NPIX2 = TB_H * TB_V;

    logic        pclk;
    logic        rst;
    logic        cap_en;
    logic        vsync;
    logic        href;
    logic [7:0]  px_data;

    logic [AW-1:0] addr0, addr1, addr2;
    logic [7:0]    data0, data2;
    logic [11:0]   data1;
    logic [2:0]    wr, fd, bsy;
`ifdef CAM_CAPTURE_STATS_EN
    logic [7:0]    fcnt0, fcnt1, fcnt2;
    logic [2:0]    ovf;
`endif

    cam_capture #(.AW(AW), .H_PIX(TB_H), .V_LINES(TB_V), .DEC(1), .FMT(0), .DW(8)) dut0 (
        .pclk(pclk), .rst(rst), .cap_en(cap_en), .vsync(vsync), .href(href), .px_data(px_data),
        .mem_px_addr(addr0), .mem_px_data(data0), .px_wr(wr[0]), .frame_done(fd[0]), .busy(bsy[0])
`ifdef CAM_CAPTURE_STATS_EN
        , .frame_cnt(fcnt0), .ovf(ovf[0])
`endif
    );

    cam_capture #(.AW(AW), .H_PIX(TB_H), .V_LINES(TB_V), .DEC(2), .FMT(1), .DW(12)) dut1 (
        .pclk(pclk), .rst(rst), .cap_en(cap_en), .vsync(vsync), .href(href), .px_data(px_data),
        .mem_px_addr(addr1), .mem_px_data(data1), .px_wr(wr[1]), .frame_done(fd[1]), .busy(bsy[1])
`ifdef CAM_CAPTURE_STATS_EN
        , .frame_cnt(fcnt1), .ovf(ovf[1])
`endif
    );

    cam_capture #(.AW(AW), .H_PIX(TB_H), .V_LINES(TB_V), .DEC(1), .FMT(2), .DW(8)) dut2 (
        .pclk(pclk), .rst(rst), .cap_en(cap_en), .vsync(vsync), .href(href), .px_data(px_data),
        .mem_px_addr(addr2), .mem_px_data(data2), .px_wr(wr[2]), .frame_done(fd[2]), .busy(bsy[2])
`ifdef CAM_CAPTURE_STATS_EN
        , .frame_cnt(fcnt2), .ovf(ovf[2])
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int vec_cnt = 0;
    int err_cnt = 0;

    int line_len [0:15];
    int byte_mem [0:15][0:39];
    int exp_q [3][$];

    // Write log filled by the monitor only; tests compare against it by offset.
    int act_addr [3][$];
    int act_data [3][$];
    int b2b_cnt [3];
    int fd_cnt [3];
    int fd_busy_bad [3];
    logic [2:0] wr_q = 3'b000;

    always @(negedge pclk) begin
        if (wr[0]) begin act_addr[0].push_back(int'(addr0)); act_data[0].push_back(int'(data0)); end
        if (wr[1]) begin act_addr[1].push_back(int'(addr1)); act_data[1].push_back(int'(data1)); end
        if (wr[2]) begin act_addr[2].push_back(int'(addr2)); act_data[2].push_back(int'(data2)); end
        for (int d = 0; d < 3; d++) begin
            if (wr[d] && wr_q[d]) b2b_cnt[d]++;
            if (fd[d]) begin
                fd_cnt[d]++;
                if (bsy[d]) fd_busy_bad[d]++;
            end
        end
        wr_q = wr;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference pixel conversion from the RGB565 byte pair.
    function automatic int conv_model(input int fmt, input int hi, input int lo);
        int r, g, b, r8, g8, b8;
        r = hi >> 3;
        g = ((hi & 7) << 3) | (lo >> 5);
        b = lo & 31;
        if (fmt == 0) return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
        if (fmt == 1) return ((r >> 1) << 8) | ((g >> 2) << 4) | (b >> 1);
        r8 = (r << 3) | (r >> 2);
        g8 = (g << 2) | (g >> 4);
        b8 = (b << 3) | (b >> 2);
        return (2 * r8 + 5 * g8 + b8) / 8;
    endfunction

    // Expected write stream of one frame; a cut line ends the frame after byte cut_byte.
    function automatic void build_expected(input int nlines, input int cut_line, input int cut_byte);
        int row, len, hi, lo;
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        row = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == cut_line) ? cut_byte + 1 : line_len[l];
            for (int c = 0; c < len / 2; c++) begin
                hi = byte_mem[l][2 * c];
                lo = byte_mem[l][2 * c + 1];
                if (c < TB_H && row < TB_V) begin
                    if (exp_q[0].size() < NPIX0) exp_q[0].push_back(conv_model(0, hi, lo));
                    if (c % 2 == 0 && row % 2 == 0 && exp_q[1].size() < NPIX1)
                        exp_q[1].push_back(conv_model(1, hi, lo));
                    if (exp_q[2].size() < NPIX2) exp_q[2].push_back(conv_model(2, hi, lo));
                end
            end
            if (len > 0) row++;
            if (l == cut_line) break;
        end
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic fill_frame(input int nlines, input int npx, input bit rand_mode, input int hi, input int lo);
        for (int l = 0; l < nlines; l++) begin
            line_len[l] = 2 * npx;
            for (int b = 0; b < 2 * npx; b++)
                byte_mem[l][b] = rand_mode ? int'($urandom_range(0, 255)) : ((b % 2 == 0) ? hi : lo);
        end
    endtask

    // Drives blank, lines and the closing vsync rise; returns before the rise is sampled unless cut.
    task automatic send_frame(input int nlines, input int cut_line, input int cut_byte);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) step();
        vsync = 1'b0;
        repeat (3) step();
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < line_len[l]; b++) begin
                href    = 1'b1;
                px_data = 8'(byte_mem[l][b]);
                if (l == cut_line && b == cut_byte) begin
                    vsync = 1'b1;
                    step();
                    href = 1'b0;
                    return;
                end
                step();
            end
            href    = 1'b0;
            px_data = 8'($urandom_range(0, 255));
            repeat (3) step();
        end
        vsync = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            vec_cnt++;
            if ({addr0, addr1, addr2} !== '0) begin
                err_cnt++;
                $display("[TB] FAIL reset_addr: got %0h/%0h/%0h expected 0", addr0, addr1, addr2);
            end
            vec_cnt++;
            if ({data0, data1, data2} !== '0) begin
                err_cnt++;
                $display("[TB] FAIL reset_data: got %0h/%0h/%0h expected 0", data0, data1, data2);
            end
            vec_cnt++;
            if (wr !== 3'b000) begin
                err_cnt++;
                $display("[TB] FAIL reset_px_wr: got %b expected 000", wr);
            end
            vec_cnt++;
            if (fd !== 3'b000) begin
                err_cnt++;
                $display("[TB] FAIL reset_frame_done: got %b expected 000", fd);
            end
            vec_cnt++;
            if (bsy !== 3'b000) begin
                err_cnt++;
                $display("[TB] FAIL reset_busy: got %b expected 000", bsy);
            end
            if (k == 0) begin
                @(negedge pclk);
                rst = 1'b1;
                repeat (2) step();
            end
        end
    endtask

    task automatic test_capture(input string name, input int nlines, input int cut_line,
                                input int cut_byte, input int drop_at);
        int base [3];
        int fdb [3];
        int bbb [3];
        int n;
        cap_en = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            base[d] = act_addr[d].size();
            fdb[d]  = fd_cnt[d];
            bbb[d]  = b2b_cnt[d];
        end
        build_expected(nlines, cut_line, cut_byte);
        vec_cnt++;
        if (bsy !== 3'b111) begin
            err_cnt++;
            $display("[TB] FAIL %s_busy_armed: got %b expected 111", name, bsy);
        end
        if (drop_at >= 0) begin
            fork
                send_frame(nlines, cut_line, cut_byte);
                begin
                    repeat (drop_at) step();
                    cap_en = 1'b0;
                end
            join
        end else begin
            send_frame(nlines, cut_line, cut_byte);
        end
        if (cut_line < 0) begin
            step();
            vec_cnt++;
            if (fd !== 3'b111) begin
                err_cnt++;
                $display("[TB] FAIL %s_frame_done_pulse: got %b expected 111", name, fd);
            end
            vec_cnt++;
            if (bsy !== 3'b000) begin
                err_cnt++;
                $display("[TB] FAIL %s_busy_drop: got %b expected 000", name, bsy);
            end
            step();
            vec_cnt++;
            if (fd !== 3'b000) begin
                err_cnt++;
                $display("[TB] FAIL %s_frame_done_width: got %b expected 000", name, fd);
            end
        end
        repeat (4) step();
        for (int d = 0; d < 3; d++) begin
            n = act_addr[d].size() - base[d];
            vec_cnt++;
            if (n != exp_q[d].size()) begin
                err_cnt++;
                $display("[TB] FAIL %s_dut%0d_write_count: got %0d expected %0d", name, d, n, exp_q[d].size());
            end
            for (int i = 0; i < n && i < exp_q[d].size(); i++) begin
                vec_cnt++;
                if (act_addr[d][base[d] + i] != i || act_data[d][base[d] + i] != exp_q[d][i]) begin
                    err_cnt++;
                    $display("[TB] FAIL %s_dut%0d_px%0d: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             name, d, i, act_addr[d][base[d] + i], act_data[d][base[d] + i], i, exp_q[d][i]);
                end
            end
            vec_cnt++;
            if (fd_cnt[d] - fdb[d] != 1) begin
                err_cnt++;
                $display("[TB] FAIL %s_dut%0d_frame_done_count: got %0d expected 1", name, d, fd_cnt[d] - fdb[d]);
            end
            vec_cnt++;
            if (b2b_cnt[d] != bbb[d] || fd_busy_bad[d] != 0) begin
                err_cnt++;
                $display("[TB] FAIL %s_dut%0d_strobe_rules: got %0d/%0d expected 0/0",
                         name, d, b2b_cnt[d] - bbb[d], fd_busy_bad[d]);
            end
        end
    endtask

    task automatic test_full_frame();
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        test_capture("full", TB_V, -1, -1, -1);
    endtask

    task automatic test_formats();
        int last;
        fill_frame(TB_V, TB_H, 1'b0, 'hF8, 'h00);
        test_capture("fmt_red", TB_V, -1, -1, -1);
        last = act_data[0].size() - 1;
        vec_cnt++;
        if (last < 0 || act_data[0][last] != 'hE0) begin
            err_cnt++;
            $display("[TB] FAIL fmt_rgb332_red: got 0x%0h expected 0xe0", (last < 0) ? -1 : act_data[0][last]);
        end
        fill_frame(TB_V, TB_H, 1'b0, 'hFF, 'hFF);
        test_capture("fmt_white", TB_V, -1, -1, -1);
        last = act_data[2].size() - 1;
        vec_cnt++;
        if (last < 0 || act_data[2][last] != 'hFF) begin
            err_cnt++;
            $display("[TB] FAIL fmt_gray_white: got 0x%0h expected 0xff", (last < 0) ? -1 : act_data[2][last]);
        end
        fill_frame(TB_V, TB_H, 1'b0, 'h00, 'h1F);
        test_capture("fmt_blue", TB_V, -1, -1, -1);
        last = act_data[2].size() - 1;
        vec_cnt++;
        if (last < 0 || act_data[2][last] != 'h1F) begin
            err_cnt++;
            $display("[TB] FAIL fmt_gray_blue: got 0x%0h expected 0x1f", (last < 0) ? -1 : act_data[2][last]);
        end
    endtask

    task automatic test_odd_byte();
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        line_len[3] = 11;
        test_capture("odd_byte", TB_V, -1, -1, -1);
    endtask

    task automatic test_vsync_cut();
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        test_capture("cut_low_byte", TB_V, 4, 9, -1);
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        test_capture("cut_high_byte", TB_V, 6, 4, -1);
    endtask

    task automatic test_reset_midline();
        int base0;
        int held [3];
        bit reached;
        cap_en = 1'b1;
        step();
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        base0   = act_addr[0].size();
        reached = 1'b0;
        fork
            send_frame(TB_V, -1, -1);
            begin
                for (int i = 0; i < 3000; i++) begin
                    if (act_addr[0].size() >= base0 + 40) begin
                        reached = 1'b1;
                        break;
                    end
                    @(negedge pclk);
                end
                rst = 1'b0;
                #1;
                vec_cnt++;
                if (!reached) begin
                    err_cnt++;
                    $display("[TB] FAIL rst_mid_reach: got %0d writes expected 40", act_addr[0].size() - base0);
                end
                vec_cnt++;
                if ({addr0, addr1, addr2, data0, data1, data2, wr, fd, bsy} !== '0) begin
                    err_cnt++;
                    $display("[TB] FAIL rst_mid_outputs: got addr %0d data 0x%0h wr %b fd %b busy %b expected all 0",
                             addr0, data0, wr, fd, bsy);
                end
                for (int d = 0; d < 3; d++) held[d] = act_addr[d].size();
                cap_en = 1'b0;
                #2;
                rst = 1'b1;
            end
        join
        repeat (6) step();
        for (int d = 0; d < 3; d++) begin
            vec_cnt++;
            if (act_addr[d].size() != held[d]) begin
                err_cnt++;
                $display("[TB] FAIL rst_mid_dut%0d_no_write: got %0d writes expected 0", d, act_addr[d].size() - held[d]);
            end
        end
        vec_cnt++;
        if (bsy !== 3'b000) begin
            err_cnt++;
            $display("[TB] FAIL rst_mid_busy: got %b expected 000", bsy);
        end
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        test_capture("after_reset", TB_V, -1, -1, -1);
    endtask

    task automatic test_cap_en_drop();
        int base [3];
        int fdb [3];
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        test_capture("cap_drop", TB_V, -1, -1, 80);
        for (int d = 0; d < 3; d++) begin
            base[d] = act_addr[d].size();
            fdb[d]  = fd_cnt[d];
        end
        fill_frame(TB_V, TB_H, 1'b1, 0, 0);
        send_frame(TB_V, -1, -1);
        repeat (4) step();
        for (int d = 0; d < 3; d++) begin
            vec_cnt++;
            if (act_addr[d].size() != base[d] || fd_cnt[d] != fdb[d]) begin
                err_cnt++;
                $display("[TB] FAIL idle_frame_dut%0d: got %0d writes %0d done expected 0 0",
                         d, act_addr[d].size() - base[d], fd_cnt[d] - fdb[d]);
            end
        end
        vec_cnt++;
        if (bsy !== 3'b000) begin
            err_cnt++;
            $display("[TB] FAIL idle_frame_busy: got %b expected 000", bsy);
        end
    endtask

    task automatic test_oversize();
        int last;
`ifdef CAM_CAPTURE_STATS_EN
        logic [7:0] fc_before;
        vec_cnt++;
        if (ovf !== 3'b000) begin
            err_cnt++;
            $display("[TB] FAIL ovf_clear: got %b expected 000", ovf);
        end
        fc_before = fcnt0;
`endif
        fill_frame(TB_V + 1, TB_H + 1, 1'b1, 0, 0);
        test_capture("oversize", TB_V + 1, -1, -1, -1);
        last = act_addr[0].size() - 1;
        vec_cnt++;
        if (last < 0 || act_addr[0][last] != NPIX0 - 1) begin
            err_cnt++;
            $display("[TB] FAIL oversize_last_addr: got %0d expected %0d", (last < 0) ? -1 : act_addr[0][last], NPIX0 - 1);
        end
        vec_cnt++;
        if (addr0 !== 8'(NPIX0 - 1)) begin
            err_cnt++;
            $display("[TB] FAIL oversize_addr_hold: got %0d expected %0d", addr0, NPIX0 - 1);
        end
`ifdef CAM_CAPTURE_STATS_EN
        vec_cnt++;
        if (ovf !== 3'b111) begin
            err_cnt++;
            $display("[TB] FAIL ovf_set: got %b expected 111", ovf);
        end
        vec_cnt++;
        if (fcnt0 !== 8'(fc_before + 8'd1)) begin
            err_cnt++;
            $display("[TB] FAIL frame_cnt: got %0d expected %0d", fcnt0, 8'(fc_before + 8'd1));
        end
`endif
    endtask

    initial begin
        rst     = 1'b0;
        cap_en  = 1'b0;
        vsync   = 1'b1;
        href    = 1'b0;
        px_data = 8'd0;
        repeat (3) @(posedge pclk);
        #1;
        $display("[TB] starting cam_capture checks");
        test_reset();
        test_full_frame();
        test_formats();
        test_odd_byte();
        test_vsync_cut();
        test_reset_midline();
        test_cap_en_drop();
        test_oversize();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
